clcd_frame_scheduler: RTL and testbench
=======================================

CLCD_FRAME_SCHEDULER -- requirements
Module: clcd_frame_scheduler

Interface
REQ-001 Parameter ROWS, default 2: number of display rows, legal range 1..4.
REQ-002 Parameter COLS, default 16: characters per row, legal range 8..40.
REQ-003 Parameter ROW_BASE, default 28'h54_14_40_00 as four 7-bit fields: DDRAM base address of row r at bits [7*r+:7].
REQ-004 clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_text  input  8*COLS*ROWS  frame text; row 0 occupies the most significant 8*COLS bits; within a row, column 0 is the most significant byte.
REQ-007 i_enable  input  1  when 0, no new row refresh starts; a row already in progress completes.
REQ-008 i_force_refresh  input  1  single-cycle pulse that marks every row dirty.
REQ-009 i_busy  input  1  downstream CLCD signal generator is busy.
REQ-010 o_data  output  8  command byte or character byte.
REQ-011 o_RS  output  1  0 = command, 1 = character data.
REQ-012 o_RW  output  1  tied to 0 (write only).
REQ-013 o_valid  output  1  o_data and o_RS are valid.
REQ-014 o_init_done  output  1  init sequence complete; stays high until reset.
REQ-015 o_frame_done  output  1  one-cycle pulse when no dirty row remains after at least one row refresh.

Function
REQ-016 Handshake: a transfer occurs on a rising edge where o_valid=1 and i_busy=0; while o_valid=1, o_data and o_RS are held stable.
REQ-017 After each transfer, o_valid goes 0 for exactly one cycle (state GAP); the next transfer is presented only after that cycle and only when i_busy=0. The downstream block raises i_busy within one cycle of acceptance.
REQ-018 States: INIT, SCAN, ADDR, CHAR, GAP; GAP returns to the state that issued the transfer.
REQ-019 INIT issues commands 0x33, 0x32, 0x28, 0x0C, 0x01, 0x06 in that order with RS=0, then sets o_init_done=1 and enters SCAN.
REQ-020 On leaving INIT, all ROWS dirty flags are set.
REQ-021 A row is dirty if its dirty flag is set or its i_text slice differs from its stored snapshot (8*COLS bits per row).
REQ-022 SCAN selects rows round-robin, starting at (last served row + 1) mod ROWS, and picks the first dirty row.
REQ-023 SCAN starts a row only when i_enable=1; it then copies that row's i_text slice into the snapshot, clears the row's dirty flag, and enters ADDR.
REQ-024 ADDR issues command 0x80 | ROW_BASE[row], RS=0, then enters CHAR with column counter = 0.
REQ-025 CHAR issues the snapshot byte at the current column, RS=1, incrementing the column after each transfer; after the transfer at column COLS-1 it returns to SCAN.
REQ-026 Characters are taken from the snapshot, never from live i_text, so a change to i_text during a refresh leaves that row dirty for a later pass.
REQ-027 If SCAN finds no dirty row and at least one row was completed since the last o_frame_done, it pulses o_frame_done.
REQ-028 i_force_refresh sets all dirty flags in any state. If it coincides with the snapshot copy for a row, the force wins and that row stays dirty.
REQ-029 If i_force_refresh arrives during INIT, it is absorbed; all rows are already set dirty on exit from INIT.
REQ-030 Row index and column counter are sized $clog2 of ROWS and COLS (minimum 1 bit) and never exceed ROWS-1 and COLS-1.

Reset
REQ-031 While reset_n=0: state=INIT with init index 0; o_valid=0, o_data=8'h00, o_RS=0, o_RW=0, o_init_done=0, o_frame_done=0; snapshots all zero; dirty flags clear; last served row = ROWS-1.
REQ-032 reset_n asserted mid-transfer aborts immediately; after release, INIT restarts from 0x33.

Verification
REQ-033 Reset release with i_busy held 0 -> six init transfers 0x33, 0x32, 0x28, 0x0C, 0x01, 0x06 (RS=0), each separated by one cycle with o_valid=0; then o_init_done=1.
REQ-034 Defaults, i_text = "HELLO WORLD     " / "FPGA CLCD TEST  " -> transfers 0x80, 16 chars of row 0, 0xC0, 16 chars of row 1, then one o_frame_done pulse.
REQ-035 After frame done, change row 1 column 3 only -> exactly 0xC0 plus the 16 bytes of row 1; row 0 is not resent.
REQ-036 i_busy held 1 for 50 cycles while o_valid=1 -> o_data and o_RS stable throughout; the transfer completes on the first cycle with i_busy=0.
REQ-037 Change row 0 text during its CHAR phase -> the old snapshot bytes finish, then row 0 is refreshed again with the new text.
REQ-038 ROWS=4, COLS=20, i_force_refresh with i_enable=0 -> no transfers; when i_enable rises, rows are refreshed in order with address commands 0x80, 0xC0, 0x94, 0xD4.

Source files
------------

// File: rtl/clcd_frame_scheduler.sv
`timescale 1ns/1ps
// Character-LCD frame scheduler: runs the HD44780 init sequence, then streams
// dirty rows (address command + row characters) to a downstream CLCD signal generator.
module clcd_frame_scheduler #(
  parameter int          ROWS     = 2,
  parameter int          COLS     = 16,
  // Four 7-bit DDRAM row bases, row r at [7*r+:7]: rows 0..3 = 0x00, 0x40, 0x14, 0x54.
  parameter logic [27:0] ROW_BASE = {7'h54, 7'h14, 7'h40, 7'h00}
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*COLS*ROWS-1:0] i_text,
  input  logic                   i_enable,
  input  logic                   i_force_refresh,
  input  logic                   i_busy,
  output logic [7:0]             o_data,
  output logic                   o_RS,
  output logic                   o_RW,
  output logic                   o_valid,
  output logic                   o_init_done,
  output logic                   o_frame_done,
  output logic [2:0]             dbg_state
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LW = 8 * COLS;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [2:0] {S_INIT, S_SCAN, S_ADDR, S_CHAR, S_GAP} state_t;

  state_t          state, state_n, ret_st, ret_st_n;
  logic [2:0]      init_idx;
  logic [RW-1:0]   row, last_row, pick_row;
  logic [CW-1:0]   col;
  logic [ROWS-1:0] dirty, row_dirty;
  logic [LW-1:0]   snap     [ROWS];
  logic [LW-1:0]   text_row [ROWS];
  logic            run, served, pick_found, issuing, xfer;
  logic            start_row, frame_pulse;
  logic [6:0]      cur_base;
  logic [7:0]      cur_char, out_byte;
  int              cand;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h33;
      3'd1:    init_cmd = 8'h32;
      3'd2:    init_cmd = 8'h28;
      3'd3:    init_cmd = 8'h0C;
      3'd4:    init_cmd = 8'h01;
      3'd5:    init_cmd = 8'h06;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  // A row needs a refresh when flagged or when its live text no longer matches what was sent.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      text_row[r]  = i_text[LW*(ROWS-1-r) +: LW];
      row_dirty[r] = dirty[r] | (text_row[r] != snap[r]);
    end
  end

  // Round-robin pick: first dirty row at or after last_row + 1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_row   = '0;
    cand       = 0;
    for (int k = 0; k < ROWS; k++) begin
      cand = int'(last_row) + 1 + k;
      if (cand >= ROWS) cand = cand - ROWS;
      for (int r = 0; r < ROWS; r++) begin
        if (!pick_found && r == cand && row_dirty[r]) begin
          pick_found = 1'b1;
          pick_row   = RW'(r);
        end
      end
    end
  end

  // Handshake: a byte moves on a rising edge with o_valid=1 and i_busy=0; o_data/o_RS
  // hold while o_valid=1, and o_valid drops for exactly one cycle (GAP) after each transfer.
  always_comb begin
    cur_base = '0;
    cur_char = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == RW'(r)) begin
        cur_base = ROW_BASE[7*r +: 7];
        for (int c = 0; c < COLS; c++) begin
          if (col == CW'(c)) cur_char = snap[r][8*(COLS-1-c) +: 8];
        end
      end
    end
    out_byte = 8'h00;
    case (state)
      S_INIT:  out_byte = init_cmd(init_idx);
      S_ADDR:  out_byte = {1'b1, cur_base};
      S_CHAR:  out_byte = cur_char;
      default: out_byte = 8'h00;
    endcase
    issuing = run && (state == S_INIT || state == S_ADDR || state == S_CHAR);
    o_valid = issuing;
    o_data  = issuing ? out_byte : 8'h00;
    o_RS    = issuing && (state == S_CHAR);
    xfer    = issuing && !i_busy;
  end

  assign o_RW      = 1'b0;
  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    ret_st_n    = ret_st;
    start_row   = 1'b0;
    frame_pulse = 1'b0;
    case (state)
      S_INIT: begin
        if (xfer) begin
          state_n  = S_GAP;
          ret_st_n = (init_idx == 3'd5) ? S_SCAN : S_INIT;
        end
      end
      S_SCAN: begin
        if (pick_found && i_enable) begin
          start_row = 1'b1;
          state_n   = S_ADDR;
        end else if (!pick_found && served) begin
          frame_pulse = 1'b1;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          state_n  = S_GAP;
          ret_st_n = S_CHAR;
        end
      end
      S_CHAR: begin
        if (xfer) begin
          state_n  = S_GAP;
          ret_st_n = (col == LAST_COL) ? S_SCAN : S_CHAR;
        end
      end
      S_GAP:   state_n = ret_st;
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_INIT;
      ret_st <= S_INIT;
    end else begin
      state  <= state_n;
      ret_st <= ret_st_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run          <= 1'b0;
      init_idx     <= 3'd0;
      row          <= '0;
      last_row     <= LAST_ROW;
      col          <= '0;
      dirty        <= '0;
      served       <= 1'b0;
      o_init_done  <= 1'b0;
      o_frame_done <= 1'b0;
      for (int r = 0; r < ROWS; r++) snap[r] <= '0;
    end else begin
      run          <= 1'b1;
      o_frame_done <= frame_pulse;
      if (frame_pulse) served <= 1'b0;
      if (state == S_INIT && xfer) begin
        init_idx <= init_idx + 3'd1;
        if (init_idx == 3'd5) begin
          o_init_done <= 1'b1;
          dirty       <= '1;
        end
      end
      if (start_row) begin
        for (int r = 0; r < ROWS; r++) begin
          if (pick_row == RW'(r)) begin
            snap[r]  <= text_row[r];
            dirty[r] <= 1'b0;
          end
        end
        row      <= pick_row;
        last_row <= pick_row;
      end
      if (state == S_ADDR && xfer) col <= '0;
      if (state == S_CHAR && xfer) begin
        if (col == LAST_COL) served <= 1'b1;
        else                 col    <= col + 1'b1;
      end
      // Placed last so a force on the same edge as a snapshot copy keeps the row dirty.
      if (i_force_refresh) dirty <= '1;
    end
  end

endmodule

// File: tb/tb_clcd_frame_scheduler.sv
`timescale 1ns/1ps
// Bench for clcd_frame_scheduler: directed frame table, multi-cycle corner sequences and
// randomized row edits checked against a row-level model of the refresh rules.
module tb_clcd_frame_scheduler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] i_text;
  logic         i_enable, i_force_refresh, i_busy;
  logic [7:0]   o_data;
  logic         o_RS, o_RW, o_valid, o_init_done, o_frame_done;
  logic [2:0]   dbg_state;

  logic [639:0] text2;
  logic         en2, force2, busy2;
  logic [7:0]   o_data2;
  logic         o_RS2, o_RW2, o_valid2, o_init_done2, o_frame_done2;
  logic [2:0]   dbg_state2;

  clcd_frame_scheduler dut (
    .clk(clk), .reset_n(reset_n), .i_text(i_text), .i_enable(i_enable),
    .i_force_refresh(i_force_refresh), .i_busy(i_busy), .o_data(o_data), .o_RS(o_RS),
    .o_RW(o_RW), .o_valid(o_valid), .o_init_done(o_init_done),
    .o_frame_done(o_frame_done), .dbg_state(dbg_state)
  );

  clcd_frame_scheduler #(.ROWS(4), .COLS(20)) dut4 (
    .clk(clk), .reset_n(reset_n), .i_text(text2), .i_enable(en2),
    .i_force_refresh(force2), .i_busy(busy2), .o_data(o_data2), .o_RS(o_RS2),
    .o_RW(o_RW2), .o_valid(o_valid2), .o_init_done(o_init_done2),
    .o_frame_done(o_frame_done2), .dbg_state(dbg_state2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [8:0]   exp_q[$];
  logic [127:0] m_snap [2];
  int           m_last;
  int           n_checks = 0, n_fail = 0;
  int           n_seen = 0, fd_cnt = 0, cyc = 0, last_cyc = 0;
  logic [7:0]   first_byte;
  logic         init_phase = 1'b0, have_prev = 1'b0;
  logic         prev_xfer = 1'b0, prev_hold = 1'b0;
  logic [8:0]   prev_byte;
  int           busy_mode = 0;
  int           xfers2 = 0, fd2 = 0;
  logic [7:0]   addr2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- downstream busy driver ----------------
  always @(posedge clk) begin
    #1;
    case (busy_mode)
      0:       i_busy = 1'b0;
      1:       i_busy = ($urandom_range(0, 3) == 0);
      default: i_busy = 1'b1;
    endcase
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_xfer = 1'b0;
      prev_hold = 1'b0;
      have_prev = 1'b0;
    end else begin
      cyc++;
      if (prev_xfer) chk("gap after transfer", o_valid, 0);
      if (prev_hold) begin
        chk("valid held while busy", o_valid, 1);
        chk("byte held while busy", {o_RS, o_data}, prev_byte);
      end
      if (o_frame_done) fd_cnt++;
      prev_xfer = o_valid && !i_busy;
      prev_hold = o_valid && i_busy;
      prev_byte = {o_RS, o_data};
      if (o_valid && !i_busy) begin
        if (init_phase && have_prev) chk("init spacing", cyc - last_cyc, 2);
        have_prev = 1'b1;
        last_cyc  = cyc;
        if (n_seen == 0) first_byte = o_data;
        n_seen++;
        chk("o_RW", o_RW, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected transfer: got %0h, expected none", {o_RS, o_data});
        end else begin
          chk("transfer byte", {o_RS, o_data}, exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && o_init_done2 && o_valid2 && !busy2) begin
      xfers2++;
      if (!o_RS2) addr2.push_back(o_data2);
    end
    if (reset_n && o_frame_done2) fd2++;
  end

  // ---------------- reference model ----------------
  task automatic push_row(input int r, input logic [127:0] t);
    logic [7:0] a;
    a = (r == 0) ? 8'h80 : 8'hC0;
    exp_q.push_back({1'b0, a});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, t[8*(15-c) +: 8]});
  endtask

  // Rows whose text changed (or all, when forced) go out once each, round-robin from last+1.
  task automatic model_frame(input logic [127:0] r0, input logic [127:0] r1,
                             input logic frc, output int n);
    logic [127:0] nt [2];
    int start, r;
    nt[0] = r0;
    nt[1] = r1;
    n     = 0;
    start = m_last;
    for (int k = 1; k <= 2; k++) begin
      r = (start + k) % 2;
      if (frc || nt[r] != m_snap[r]) begin
        push_row(r, nt[r]);
        m_snap[r] = nt[r];
        m_last    = r;
        n += 17;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_frame(input int exp_n);
    int t;
    t = 0;
    if (exp_n == 0) begin
      repeat (40) @(negedge clk);
    end else begin
      while ((exp_q.size() != 0 || fd_cnt == 0) && t < 4000) begin
        @(negedge clk);
        t++;
      end
      chk("frame completes in time", (t < 4000), 1);
      repeat (6) @(negedge clk);
    end
    chk("frame_done pulses", fd_cnt, (exp_n > 0) ? 1 : 0);
    chk("expected queue drained", exp_q.size(), 0);
  endtask

  task automatic apply_frame(input logic [127:0] r0, input logic [127:0] r1,
                             input logic frc, output int n_exp);
    model_frame(r0, r1, frc, n_exp);
    n_seen = 0;
    fd_cnt = 0;
    if (frc) begin
      @(posedge clk); #1 i_force_refresh = 1'b1;
      @(posedge clk); #1 i_force_refresh = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    i_text = {r0, r1};
    wait_frame(n_exp);
  endtask

  task automatic run_init();
    int n, t;
    exp_q.delete();
    m_snap[0] = '0;
    m_snap[1] = '0;
    m_last    = 1;
    foreach (init_seq[i]) exp_q.push_back({1'b0, init_seq[i]});
    model_frame(i_text[255:128], i_text[127:0], 1'b1, n);
    n_seen     = 0;
    fd_cnt     = 0;
    init_phase = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    t = 0;
    while (!o_init_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    init_phase = 1'b0;
    chk("o_init_done after init", o_init_done, 1);
    chk("init transfers before done", n_seen, 6);
    wait_frame(n);
    chk("init frame transfers", n_seen, 6 + n);
  endtask

  logic [7:0] init_seq [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h01, 8'h06};

  // ---------------- directed table ----------------
  typedef struct {
    logic [127:0] r0;
    logic [127:0] r1;
    logic         frc;
    int           exp_n;
    logic [7:0]   exp_first;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, sel, c;
    logic [127:0] r0, r1, t1, t2;
    logic         frc;

    vecs[0] = '{"HELLO WORLD     ", "FPGA CLCD TEST  ", 1'b0, 34, 8'h80};
    vecs[1] = '{"HELLO WORLD     ", "FPGX CLCD TEST  ", 1'b0, 17, 8'hC0};
    vecs[2] = '{"HELLO WORLD     ", "FPGX CLCD TEST  ", 1'b0, 0,  8'h00};
    vecs[3] = '{"HELLO WORLD     ", "FPGX CLCD TEST  ", 1'b1, 34, 8'h80};
    vecs[4] = '{"JELLO WORLD     ", "FPGX CLCD TEST  ", 1'b0, 17, 8'h80};
    vecs[5] = '{"ABCDEFGHIJKLMNOP", "qrstuvwxyz012345", 1'b0, 34, 8'hC0};

    reset_n         = 1'b0;
    i_text          = '0;
    i_enable        = 1'b1;
    i_force_refresh = 1'b0;
    i_busy          = 1'b0;
    en2             = 1'b0;
    force2          = 1'b0;
    busy2           = 1'b0;
    for (int i = 0; i < 20; i++) text2[32*i +: 32] = $urandom();

    repeat (3) @(negedge clk);
    chk("reset o_valid", o_valid, 0);
    chk("reset o_data", o_data, 0);
    chk("reset o_RS", o_RS, 0);
    chk("reset o_RW", o_RW, 0);
    chk("reset o_init_done", o_init_done, 0);
    chk("reset o_frame_done", o_frame_done, 0);

    run_init();

    foreach (vecs[i]) begin
      apply_frame(vecs[i].r0, vecs[i].r1, vecs[i].frc, n);
      chk($sformatf("vec%0d transfers", i), n_seen, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) chk($sformatf("vec%0d first cmd", i), first_byte, vecs[i].exp_first);
    end

    // Long busy stall with a byte pending.
    busy_mode = 2;
    repeat (2) @(posedge clk);
    model_frame(m_snap[0], "BUSY HOLD TEST  ", 1'b0, n);
    n_seen = 0;
    fd_cnt = 0;
    @(posedge clk); #1 i_text[127:0] = "BUSY HOLD TEST  ";
    t = 0;
    while (!o_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("valid before stall", o_valid, 1);
    repeat (50) @(negedge clk);
    chk("stalled valid", o_valid, 1);
    chk("stalled byte", {o_RS, o_data}, exp_q[0]);
    busy_mode = 0;
    wait_frame(n);
    chk("stall frame transfers", n_seen, n);

    // Row 0 edited mid-refresh: old snapshot finishes, then row 0 goes again.
    busy_mode = 1;
    t1 = "ROW ZERO FIRST  ";
    t2 = "ROW ZERO SECOND ";
    n_seen = 0;
    fd_cnt = 0;
    push_row(0, t1);
    push_row(0, t2);
    m_snap[0] = t2;
    m_last    = 0;
    @(posedge clk); #1 i_text[255:128] = t1;
    t = 0;
    while (n_seen < 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reached row0 chars", (n_seen >= 5), 1);
    @(posedge clk); #1 i_text[255:128] = t2;
    wait_frame(34);
    chk("row0 rerun transfers", n_seen, 34);

    // Randomized row edits, forces and busy patterns.
    for (int it = 0; it < 24; it++) begin
      r0  = m_snap[0];
      r1  = m_snap[1];
      sel = $urandom_range(0, 3);
      if (sel & 1) begin
        c = $urandom_range(0, 15);
        r0[8*c +: 8] = 8'($urandom_range(32, 126));
      end
      if (sel & 2) begin
        c = $urandom_range(0, 15);
        r1[8*c +: 8] = 8'($urandom_range(32, 126));
      end
      frc = ($urandom_range(0, 3) == 0);
      apply_frame(r0, r1, frc, n);
      chk($sformatf("random%0d transfers", it), n_seen, n);
    end
    busy_mode = 0;

    // Four-row display: force while disabled sends nothing until enable rises.
    chk("4-row init done", o_init_done2, 1);
    @(posedge clk); #1 force2 = 1'b1;
    @(posedge clk); #1 force2 = 1'b0;
    repeat (30) @(negedge clk);
    chk("4-row disabled transfers", xfers2, 0);
    @(posedge clk); #1 en2 = 1'b1;
    t = 0;
    while (fd2 == 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("4-row frame done", fd2, 1);
    chk("4-row transfers", xfers2, 84);
    chk("4-row address count", addr2.size(), 4);
    if (addr2.size() == 4) begin
      chk("4-row addr0", addr2[0], 8'h80);
      chk("4-row addr1", addr2[1], 8'hC0);
      chk("4-row addr2", addr2[2], 8'h94);
      chk("4-row addr3", addr2[3], 8'hD4);
    end

    // Reset in the middle of a pending transfer.
    busy_mode = 2;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 i_text[255:128] = "RESET MID XFER  ";
    t = 0;
    while (!o_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("valid before reset", o_valid, 1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("async reset o_valid", o_valid, 0);
    chk("async reset o_data", o_data, 0);
    chk("async reset o_init_done", o_init_done, 0);
    busy_mode = 0;
    repeat (3) @(negedge clk);
    run_init();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
